// File: rtl/i2c_recv.sv
// I2C slave-side write receiver: address match, register address, auto-incrementing data bytes.
// Define I2C_RECV_FILTER_EN to add a FILTER_DEPTH-sample debounce on scl/sda after the synchronisers.
module i2c_recv #(
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER_DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       recvEnable,
   input  logic [6:0] devAddr,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] regAddr,
   output logic [7:0] regData,
   output logic       dataValid,
   output logic       done,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // Strobe interface: dataValid is high for exactly one cycle per accepted byte, with no
   // backpressure; regAddr/regData are stable while it is high and hold until the next update.

   if (SYNC_STAGES < 2 || FILTER_DEPTH < 1) begin : g_bad_param
      $error("i2c_recv: SYNC_STAGES must be >= 2 and FILTER_DEPTH >= 1");
   end

   typedef enum logic [2:0] {
      IDLE, RX_ADDR, ACK_ADDR, RX_REG, ACK_REG, RX_DATA, ACK_DATA, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_f, sda_f, scl_d, sda_d;
   logic scl_rise, scl_fall, start_evt, stop_evt;

   // Synchronisers idle at 1 so that a released bus produces no events out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else if (!recvEnable) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      end
   end

`ifdef I2C_RECV_FILTER_EN
   localparam int FW = $clog2(FILTER_DEPTH + 1);
   logic [FW-1:0] scl_cnt, sda_cnt;

   // The filtered level flips only after FILTER_DEPTH consecutive samples disagree with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_f   <= 1'b1;
         sda_f   <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         if (scl_sync[SYNC_STAGES-1] == scl_f) scl_cnt <= '0;
         else if (scl_cnt == FW'(FILTER_DEPTH - 1)) begin
            scl_f   <= ~scl_f;
            scl_cnt <= '0;
         end else scl_cnt <= scl_cnt + FW'(1);
         if (sda_sync[SYNC_STAGES-1] == sda_f) sda_cnt <= '0;
         else if (sda_cnt == FW'(FILTER_DEPTH - 1)) begin
            sda_f   <= ~sda_f;
            sda_cnt <= '0;
         end else sda_cnt <= sda_cnt + FW'(1);
      end
   end
`else
   assign scl_f = scl_sync[SYNC_STAGES-1];
   assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_d;
   assign scl_fall  = ~scl_f & scl_d;
   assign start_evt = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_evt  = scl_f & scl_d & ~sda_d & sda_f;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] shift, shift_nxt, byte_in, addr_nxt, data_nxt;
   logic       ack_drive, drive_nxt, got_data, got_nxt;
   logic       busy_nxt, valid_nxt, done_nxt, byte_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shift     <= '0;
         ack_drive <= 1'b0;
         got_data  <= 1'b0;
         busy      <= 1'b0;
         dataValid <= 1'b0;
         done      <= 1'b0;
         regAddr   <= '0;
         regData   <= '0;
      end else if (!recvEnable) begin
         state     <= IDLE;
         cnt       <= '0;
         shift     <= '0;
         ack_drive <= 1'b0;
         got_data  <= 1'b0;
         busy      <= 1'b0;
         dataValid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift     <= shift_nxt;
         ack_drive <= drive_nxt;
         got_data  <= got_nxt;
         busy      <= busy_nxt;
         dataValid <= valid_nxt;
         done      <= done_nxt;
         regAddr   <= addr_nxt;
         regData   <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift;
      drive_nxt = ack_drive;
      got_nxt   = got_data;
      busy_nxt  = busy;
      addr_nxt  = regAddr;
      data_nxt  = regData;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      byte_in   = {shift[6:0], sda_f};
      byte_end  = scl_rise && (cnt == 4'd7);
      if (stop_evt) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         drive_nxt = 1'b0;
         busy_nxt  = 1'b0;
         done_nxt  = got_data;
         got_nxt   = 1'b0;
      end else if (start_evt) begin
         state_nxt = RX_ADDR;
         cnt_nxt   = '0;
         drive_nxt = 1'b0;
         busy_nxt  = 1'b0;
         got_nxt   = 1'b0;
      end else begin
         if (scl_rise && (state == RX_ADDR || state == RX_REG || state == RX_DATA)) begin
            shift_nxt = byte_in;
            cnt_nxt   = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
         end
         case (state)
            RX_ADDR: if (byte_end) begin
               // Only writes to our own address are acknowledged.
               if (byte_in[7:1] == devAddr && !byte_in[0]) begin
                  state_nxt = ACK_ADDR;
                  busy_nxt  = 1'b1;
               end else state_nxt = IGNORE;
            end
            RX_REG: if (byte_end) state_nxt = ACK_REG;
            RX_DATA: if (byte_end) begin
               data_nxt  = byte_in;
               valid_nxt = 1'b1;
               got_nxt   = 1'b1;
               state_nxt = ACK_DATA;
            end
            ACK_ADDR, ACK_REG, ACK_DATA: if (scl_fall) begin
               // First fall ends bit 8 and starts the ACK; second fall ends the ACK clock.
               if (!ack_drive) drive_nxt = 1'b1;
               else begin
                  drive_nxt = 1'b0;
                  case (state)
                     ACK_ADDR: state_nxt = RX_REG;
                     ACK_REG: begin
                        state_nxt = RX_DATA;
                        addr_nxt  = shift;
                     end
                     default: begin
                        state_nxt = RX_DATA;
                        addr_nxt  = regAddr + 8'd1;
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign sda       = (ack_drive && recvEnable) ? 1'b0 : 1'bz;
   assign state_dbg = state;

endmodule
